fsm_yoye_rx: RTL

Receive-side keyword detector for the UART terminal project. Consumes the byte stream from the UART receiver (`data_i` qualified by the one-cycle `eor_i` strobe) and recognises the four-byte keyword "yoye" (0x79, 0x6F, 0x79, 0x65). It sits between `uart_rx` and the terminal control logic: it pulses `match_o` on each complete keyword, counts matches, abandons a partial match after an inter-byte timeout, and optionally echoes every received byte back through the UART transmitter handshake.

---
 rtl/fsm_yoye_rx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fsm_yoye_rx.sv
// fsm_yoye_rx: keyword detector for the byte stream coming out of uart_rx.
// Recognises "yoye" (0x79 0x6F 0x79 0x65) with overlap-correct restart,
// counts matches, drops a partial match after TIMEOUT_CYC idle cycles.
// Optional echo path (bytes sent back through the uart_tx handshake)
// is built only when FSM_YOYE_RX_ECHO_EN is defined.
module fsm_yoye_rx #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       eor_i,
    input  logic [7:0] data_i,
    input  logic       clr_i,
    input  logic       eot_i,
    output logic       match_o,
    output logic       busy_o,
    output logic       to_o,
    output logic [7:0] hits_o,
    output logic       sttx_o,
    output logic [7:0] echo_o,
    output logic       ovf_o
);

    localparam logic [7:0] CH_Y = 8'h79;
    localparam logic [7:0] CH_O = 8'h6F;
    localparam logic [7:0] CH_E = 8'h65;

    // Counter only needs to reach TIMEOUT_CYC-1.
    localparam int            CW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, G1, G2, G3} state_t;

    state_t        state, state_n;
    logic [CW-1:0] to_cnt, to_cnt_n;
    logic          match_n, to_n, expired;
    state_t        restart;

    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign expired = (state != IDLE) && (to_cnt == TO_LAST) && !eor_i;

    // Where a wrong byte lands: a fresh 'y' can always start a new keyword.
    assign restart = (data_i == CH_Y) ? G1 : IDLE;

    // Matcher next-state, pulse generation and timeout counter update.
    always_comb begin
        state_n  = state;
        match_n  = 1'b0;
        to_n     = 1'b0;
        to_cnt_n = to_cnt;
        if (eor_i) begin
            to_cnt_n = '0;
            unique case (state)
                IDLE: state_n = restart;
                G1:   state_n = (data_i == CH_O) ? G2 : restart;
                G2:   state_n = (data_i == CH_Y) ? G3 : IDLE;
                G3: begin
                    if (data_i == CH_E) begin
                        state_n = IDLE;
                        match_n = 1'b1;
                    end else if (data_i == CH_O) begin
                        // "yoy" + 'o' still ends in "yo".
                        state_n = G2;
                    end else begin
                        state_n = restart;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (expired) begin
            state_n  = IDLE;
            to_n     = 1'b1;
            to_cnt_n = '0;
        end else if (state == IDLE) begin
            to_cnt_n = '0;
        end else begin
            to_cnt_n = to_cnt + 1'b1;
        end
    end

    // Matcher registers; every output is taken straight from a flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            to_cnt  <= '0;
            match_o <= 1'b0;
            to_o    <= 1'b0;
            busy_o  <= 1'b0;
            hits_o  <= 8'h00;
        end else begin
            state   <= state_n;
            to_cnt  <= to_cnt_n;
            match_o <= match_n;
            to_o    <= to_n;
            busy_o  <= (state_n != IDLE);
            if (clr_i)        hits_o <= 8'h00;
            else if (match_n) hits_o <= hits_o + 8'h01;
        end
    end

`ifdef FSM_YOYE_RX_ECHO_EN

    typedef enum logic [1:0] {E_IDLE, E_SEND, E_WAIT} echo_t;

    echo_t e_state, e_state_n;

    // Echo handshake: accept a byte only when idle, request tx, wait for eot.
    always_comb begin
        e_state_n = e_state;
        unique case (e_state)
            E_IDLE:  if (eor_i) e_state_n = E_SEND;
            E_SEND:  e_state_n = E_WAIT;
            E_WAIT:  if (eot_i) e_state_n = E_IDLE;
            default: e_state_n = E_IDLE;
        endcase
    end

    // Echo registers: sttx is high exactly while in E_SEND, overflow is sticky.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e_state <= E_IDLE;
            sttx_o  <= 1'b0;
            echo_o  <= 8'h00;
            ovf_o   <= 1'b0;
        end else begin
            e_state <= e_state_n;
            sttx_o  <= (e_state_n == E_SEND);
            if (eor_i && e_state == E_IDLE) echo_o <= data_i;
            if (clr_i)                              ovf_o <= 1'b0;
            else if (eor_i && e_state != E_IDLE)    ovf_o <= 1'b1;
        end
    end

`else

    // Echo path absent: outputs tied off, eot_i has no load.
    logic unused_eot;
    assign unused_eot = eot_i;
    assign sttx_o     = 1'b0;
    assign echo_o     = 8'h00;
    assign ovf_o      = 1'b0;

`endif

endmodule
